mem_stage: RTL

- Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Accepts the execute-stage bus and waits for the data-SRAM read response on loads.
- Byte-selects and sign/zero-extends load data, then forwards the final result to write-back.
- Exports a hazard/forward bus so decode can stall or bypass.
- Supports variable-latency data SRAM (data_ok may arrive 1..N cycles after the request).
- Buffers the returned data if write-back is not accepting.

---
 rtl/mem_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. It waits on variable-latency load data,
// byte-selects and extends it, and exports a hazard/forward bus to decode.
`default_nettype none

module mem_stage #(
    parameter int ES_TO_MS_BUS_WD  = 74,
    parameter int MS_TO_WS_BUS_WD  = 70,
    parameter int MS_HAZARD_BUS_WD = 40
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        ws_allowin,
    output logic                        ms_allowin,
    input  logic                        es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus,
    output logic                        ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
    input  logic                        data_sram_data_ok,
    input  logic [31:0]                 data_sram_rdata,
    output logic [MS_HAZARD_BUS_WD-1:0] ms_hazard_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    logic [31:0]                r_rdata_buf;

    logic [2:0]  w_ld_op;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic        w_is_load;
    logic        w_ready_go;
    logic        w_res_ready;
    logic        w_allowin;
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_final;

    assign {w_ld_op, w_res_from_mem, w_gr_we, w_dest, w_alu_result, w_pc} = r_bus;

    assign w_is_load   = r_ms_valid && w_res_from_mem;
    assign w_ready_go  = !w_res_from_mem || (r_state == S_HELD) || data_sram_data_ok;
    assign w_res_ready = !w_res_from_mem || w_ready_go;
    assign w_allowin   = !r_ms_valid || (w_ready_go && ws_allowin);

    // Returned data is used the cycle it arrives; the buffer only matters once HELD.
    assign w_raw  = (r_state == S_HELD) ? r_rdata_buf : data_sram_rdata;
    assign w_half = w_alu_result[1] ? w_raw[31:16] : w_raw[15:0];

    always_comb begin
        w_byte = w_raw[7:0];
        case (w_alu_result[1:0])
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            2'd3:    w_byte = w_raw[31:24];
            default: w_byte = w_raw[7:0];
        endcase
    end

    always_comb begin
        w_load_data = w_raw;
        case (w_ld_op)
            3'b001:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b010:  w_load_data = {24'd0, w_byte};
            3'b011:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_raw;
        endcase
    end

    assign w_final = w_res_from_mem ? w_load_data : w_alu_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid  <= 1'b0;
            r_state     <= S_IDLE;
            r_rdata_buf <= 32'd0;
            r_bus       <= '0;
        end else begin
            if (w_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && w_allowin) begin
                r_bus <= es_to_ms_bus;
            end
            // Leaving (or empty) always restarts the FSM for whatever enters next.
            if (w_allowin) begin
                r_state <= S_IDLE;
            end else if (w_is_load && r_state != S_HELD) begin
                if (data_sram_data_ok) begin
                    r_rdata_buf <= data_sram_rdata;
                    r_state     <= S_HELD;
                end else begin
                    r_state <= S_WAIT;
                end
            end
        end
    end

    assign ms_allowin     = w_allowin;
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;
    assign ms_to_ws_bus   = {w_gr_we, w_dest, w_final, w_pc};
    assign ms_hazard_bus  = {r_ms_valid, w_gr_we, w_dest, w_res_ready, w_final};

    a_data_ok_expected: assert property (@(posedge clk) disable iff (!resetn)
        data_sram_data_ok |-> w_is_load)
        else $warning("data_ok with no load in flight, ignored");

endmodule

`default_nettype wire
